// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial packed-BCD adder with IDLE/RUN/DONE control.
// One BCD digit is processed per clock, from the least significant digit up.
// Optional subtraction (nine's complement of B plus a forced carry-in) is
// compiled in when the macro BCD_SUB_EN is defined.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  begin an operation (sampled only in IDLE)
//   a, b   packed BCD operands, digit 0 in bits [3:0]
//   cin    carry into digit 0
//   sub    (BCD_SUB_EN only) subtract b from a
//   busy   high while digits are being processed
//   done   one-cycle pulse when sum/cout/err are valid
//   sum    packed BCD result
//   cout   carry out of the most significant digit
//   err    an operand digit exceeded 9 during the last operation
module bcd_serial_add_ctrl #(
  parameter int unsigned NDIG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
`ifdef BCD_SUB_EN
  input  logic              sub,
`endif
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam int unsigned W     = 4 * NDIG;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               carry_q, carry_d;
  logic               sub_q, sub_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       sum_d;
  logic               cout_d, err_d, busy_d, done_d;
  logic               sub_in;

  logic [3:0]         b_eff;
  logic [4:0]         t;
  logic [3:0]         dig;
  logic               c_next;

`ifdef BCD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      sum     <= sum_d;
      cout    <= cout_d;
      err     <= err_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Current-digit arithmetic; operands are shifted so the active digit sits in [3:0]
  always_comb begin
    b_eff = sub_q ? 4'(4'd9 - b_q[3:0]) : b_q[3:0];
    t     = 5'(a_q[3:0]) + 5'(b_eff) + 5'(carry_q);
    if (t > 5'd9) begin
      dig    = 4'(t + 5'd6);
      c_next = 1'b1;
    end else begin
      dig    = t[3:0];
      c_next = 1'b0;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    sum_d   = sum;
    cout_d  = cout;
    err_d   = err;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub_in;
          carry_d = sub_in ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = dig;
        end
        // err looks at the raw operand digits, before any complementing
        if (a_q[3:0] > 4'd9 || b_q[3:0] > 4'd9) err_d = 1'b1;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = c_next;
        if (idx_q == IDX_W'(NDIG - 1)) begin
          cout_d  = c_next;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (NDIG = 3): directed cases plus
// randomized operations checked against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

  localparam int NDIG = 3;
  localparam int W    = 4 * NDIG;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a, b;
  logic          cin;
  logic          sub;
  logic          busy, done, cout, err;
  logic [W-1:0]  sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef BCD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    int m = 1;
    for (int i = 0; i < NDIG; i++) begin
      r += int'(v[4*i +: 4]) * m;
      m *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int x = n;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal reference: add, or a - b via ten's complement when subtracting
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                       input logic tsub, output logic [W-1:0] es, output logic ec);
    int va = bcd2int(ta);
    int vb = bcd2int(tb_);
    int tot;
    if (tsub) tot = va + (999 - vb) + 1;
    else      tot = va + vb + int'(tcin);
    es = int2bcd(tot % 1000);
    ec = (tot >= 1000);
  endtask

  // One full operation with timing checks; hold_start keeps start high through RUN/DONE
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tcin, input logic tsub, input logic hold_start,
                       output logic [W-1:0] rs, output logic rc, output logic re);
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check({tag, "_acc_busy"}, 32'(busy), 32'd1);
    check({tag, "_acc_clr"}, {18'd0, sum, cout, err}, 32'd0);
    for (int i = 0; i < NDIG - 1; i++) begin
      @(posedge clk); #1;
      check({tag, "_run"}, {30'd0, busy, done}, 32'd2);
    end
    @(posedge clk); #1;
    check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
    rs = sum; rc = cout; re = err;
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    start = 1'b0;
    if (hold_start) begin
      @(posedge clk); #1;
      check({tag, "_noq"}, {30'd0, busy, done}, 32'd0);
    end
  endtask

  logic [W-1:0] rs, es, ra, rb;
  logic         rc, re, ec, rcin, rsub;

  initial begin
    rst = 1'b1; start = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {18'd0, sum, cout, err}, 32'd0);
    check("reset_ctl", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    do_op("r029", 12'h123, 12'h456, 1'b0, 1'b0, 1'b0, rs, rc, re);
    check("r029_res", {19'd0, rs, rc}, {19'd0, 12'h579, 1'b0});
    check("r029_err", 32'(re), 32'd0);

    do_op("r030a", 12'h999, 12'h001, 1'b0, 1'b0, 1'b0, rs, rc, re);
    check("r030a_res", {19'd0, rs, rc}, {19'd0, 12'h000, 1'b1});
    do_op("r030b", 12'h999, 12'h999, 1'b1, 1'b0, 1'b0, rs, rc, re);
    check("r030b_res", {19'd0, rs, rc}, {19'd0, 12'h999, 1'b1});

    do_op("r031a", 12'h1A0, 12'h000, 1'b0, 1'b0, 1'b0, rs, rc, re);
    check("r031a_err", 32'(re), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("r031_hold", 32'(err), 32'd1);
    do_op("r031b", 12'h100, 12'h000, 1'b0, 1'b0, 1'b0, rs, rc, re);
    check("r031b_res", {18'd0, rs, rc, re}, {18'd0, 12'h100, 2'b00});

    do_op("hold", 12'h250, 12'h250, 1'b1, 1'b0, 1'b1, rs, rc, re);
    check("hold_res", {19'd0, rs, rc}, {19'd0, 12'h501, 1'b0});

    // Reset at edge k+2 of a running operation
    @(negedge clk);
    a = 12'h111; b = 12'h222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort_pre", {18'd0, sum, busy, done}, {18'd0, 12'h003, 2'b10});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_rst", {17'd0, sum, cout, err, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_nodone", {30'd0, busy, done}, 32'd0);
    do_op("post_rst", 12'h048, 12'h052, 1'b0, 1'b0, 1'b0, rs, rc, re);
    check("post_rst_res", {19'd0, rs, rc}, {19'd0, 12'h100, 1'b0});

`ifdef BCD_SUB_EN
    do_op("r033a", 12'h500, 12'h123, 1'b0, 1'b1, 1'b0, rs, rc, re);
    check("r033a_res", {19'd0, rs, rc}, {19'd0, 12'h377, 1'b1});
    do_op("r033b", 12'h123, 12'h500, 1'b0, 1'b1, 1'b0, rs, rc, re);
    check("r033b_res", {19'd0, rs, rc}, {19'd0, 12'h623, 1'b0});
`endif

    for (int n = 0; n < 200; n++) begin
      ra   = int2bcd(int'($urandom_range(0, 999)));
      rb   = int2bcd(int'($urandom_range(0, 999)));
      rcin = 1'($urandom);
`ifdef BCD_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      model(ra, rb, rcin, rsub, es, ec);
      do_op("rnd", ra, rb, rcin, rsub, 1'b0, rs, rc, re);
      check("rnd_res", {18'd0, rs, rc, re}, {18'd0, es, ec, 1'b0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
